timer_unit: RTL and testbench

- Millisecond down-counting timer peripheral at the far end of the CPU register-file timer interface.
- Consumes the timer duration, start and interrupt-enable register bytes driven by the register file.
- Returns a done level to the register file and a one-cycle interrupt request to the interrupt status logic.
- Contains a cycle prescaler, a millisecond counter, start edge detection and a 3-state FSM.

---
 rtl/timer_unit.sv | 115 +++++++++++
 tb/tb_timer_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_unit.sv
// Millisecond down-counting timer: a cycle prescaler divides the clock into
// millisecond ticks, and a 3-state FSM tracks idle / counting / finished.
module timer_unit #(
    parameter int CLK_HZ = 27000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] time_ms,
    input  logic [7:0]  start,
    input  logic [7:0]  interrupt_enable,
    output logic        done,
    output logic        busy,
    output logic        interrupt
);

    localparam int CYCLES_PER_MS = CLK_HZ / 1000;
    localparam int PRE_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CYCLES_PER_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0]      rem_q, rem_d;
    logic             start_prev_q;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             irq_q, irq_d;

    logic start_lvl;
    logic start_edge;
    logic ms_tick;
    logic terminal;

    assign start_lvl  = |start;
    assign start_edge = start_lvl & ~start_prev_q;
    assign ms_tick    = (pre_q == PRE_MAX);
    // Terminal count is the last prescaler cycle of the last millisecond.
    assign terminal   = (state_q == S_RUN) && ms_tick && (rem_q == 16'd1);

    // State register and all datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pre_q        <= '0;
            rem_q        <= '0;
            start_prev_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            rem_q        <= rem_d;
            start_prev_q <= start_lvl;
            done_q       <= done_d;
            busy_q       <= busy_d;
            irq_q        <= irq_d;
        end
    end

    // Next-state logic; a start edge overrides every state, including a
    // terminal count on the same cycle.
    always_comb begin
        state_d = state_q;
        if (start_edge) begin
            state_d = (time_ms == 16'd0) ? S_DONE : S_RUN;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_RUN:   state_d = terminal ? S_DONE : S_RUN;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pre_d = pre_q;
        rem_d = rem_q;
        if (start_edge) begin
            pre_d = '0;
            rem_d = time_ms;
        end else if (state_q == S_RUN) begin
            if (ms_tick) begin
                pre_d = '0;
                rem_d = rem_q - 16'd1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Output logic: registered levels follow the next state; the interrupt
    // samples the enable only on the completing edge.
    always_comb begin
        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_RUN);
        irq_d  = 1'b0;
        if (start_edge) begin
            irq_d = (time_ms == 16'd0) && (|interrupt_enable);
        end else if (terminal) begin
            irq_d = |interrupt_enable;
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_timer_unit.sv
// Bench for timer_unit: directed scenarios plus random segments, checked per
// cycle against a deadline-based reference model through an expected queue.
module tb_timer_unit;

    localparam int CLK_HZ = 4000;
    localparam int CPM    = CLK_HZ / 1000;

    logic        clk;
    logic        rst;
    logic [15:0] time_ms;
    logic [7:0]  start;
    logic [7:0]  interrupt_enable;
    logic        done;
    logic        busy;
    logic        interrupt;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];

    // Reference model state: a run is described only by its completion cycle.
    int m_cyc      = 0;
    bit m_prev     = 1'b0;
    bit m_running  = 1'b0;
    bit m_done     = 1'b0;
    int m_deadline = 0;

    timer_unit #(.CLK_HZ(CLK_HZ)) dut (
        .clk              (clk),
        .rst              (rst),
        .time_ms          (time_ms),
        .start            (start),
        .interrupt_enable (interrupt_enable),
        .done             (done),
        .busy             (busy),
        .interrupt        (interrupt)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model the edge about to happen with the inputs currently driven.
    task automatic model_step();
        bit lvl;
        bit edge_seen;
        bit irq;
        irq = 1'b0;
        if (rst) begin
            m_prev    = 1'b0;
            m_running = 1'b0;
            m_done    = 1'b0;
        end else begin
            m_cyc++;
            lvl       = (start != 8'd0);
            edge_seen = lvl && !m_prev;
            m_prev    = lvl;
            if (edge_seen) begin
                m_done = 1'b0;
                if (time_ms == 16'd0) begin
                    m_done    = 1'b1;
                    m_running = 1'b0;
                    irq       = (interrupt_enable != 8'd0);
                end else begin
                    m_running  = 1'b1;
                    m_deadline = m_cyc + int'(time_ms) * CPM;
                end
            end else if (m_running && m_cyc == m_deadline) begin
                m_running = 1'b0;
                m_done    = 1'b1;
                irq       = (interrupt_enable != 8'd0);
            end
        end
        exp_q.push_back({m_done, m_running, irq});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_now(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop before any edge.
    task automatic async_reset_pulse();
        @(negedge clk);
        #1;
        start = 8'd0;
        rst   = 1'b1;
        #1;
        check_now("reset_async_done", done, 1'b0);
        check_now("reset_async_busy", busy, 1'b0);
        check_now("reset_async_irq", interrupt, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every cycle's outputs are compared with the next expected entry.
    always @(negedge clk) begin
        logic [2:0] exp_v;
        logic [2:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {done, busy, interrupt};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_%0d {done,busy,irq}: got %b expected %b",
                         m_cyc, act_v, exp_v);
            end
        end
    end

    initial begin
        rst              = 1'b1;
        start            = 8'd0;
        time_ms          = 16'd0;
        interrupt_enable = 8'd0;
        ticks(3);
        rst = 1'b0;
        ticks(10);

        // Nominal run, then start held high.
        time_ms = 16'd3; interrupt_enable = 8'd1; start = 8'd1;
        ticks(13 + 20);

        // Zero duration with a high enable bit.
        start = 8'd0; tick();
        time_ms = 16'd0; interrupt_enable = 8'h80; start = 8'd1;
        ticks(4);

        // Interrupt disabled, enabled too late, start dropped and re-raised.
        start = 8'd0; tick();
        time_ms = 16'd2; interrupt_enable = 8'd0; start = 8'd1;
        ticks(10);
        interrupt_enable = 8'd1; ticks(5);
        start = 8'd0; ticks(3);
        start = 8'd4; ticks(12);

        // Retrigger with time change.
        start = 8'd0; tick();
        time_ms = 16'd5; start = 8'd1; tick();
        tick();
        time_ms = 16'd9; ticks(3);
        start = 8'd0; ticks(2);
        time_ms = 16'd2; start = 8'd1;
        ticks(12);

        // Reset mid-run.
        start = 8'd0; tick();
        time_ms = 16'd4; start = 8'd1; ticks(6);
        async_reset_pulse();
        ticks(30);

        // Start edge coincides with terminal count.
        time_ms = 16'd1; interrupt_enable = 8'd1; start = 8'd1; tick();
        start = 8'd0; ticks(3);
        start = 8'd2; ticks(8);

        // Maximum duration: counts, then is retriggered with a short run.
        start = 8'd0; tick();
        time_ms = 16'hFFFF; start = 8'd1; ticks(20);
        start = 8'd0; tick();
        time_ms = 16'd1; start = 8'd1; ticks(6);

        // Random segments.
        for (int s = 0; s < 40; s++) begin
            time_ms = 16'($urandom_range(0, 6));
            interrupt_enable = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            start = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            ticks($urandom_range(1, 15));
            if ($urandom_range(0, 19) == 0) begin
                async_reset_pulse();
            end
        end
        ticks(30);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
